// File: rtl/card_pkg.sv
// Shared types and constants for the memory-game turn sequencer.
package card_pkg;

    localparam int N_CARDS = 16;
    localparam int SYM_W   = 3;
    localparam int CARD_W  = 5;
    localparam int N_PAIRS = N_CARDS / 2;

    // Card status as drawn by the video generator in bits [4:3] of each card word.
    typedef enum logic [1:0] {
        ST_HIDDEN  = 2'b00,
        ST_FACE_UP = 2'b01,
        ST_MATCHED = 2'b10
    } card_status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK1,
        S_PICK2,
        S_CHECK,
        S_SHOW,
        S_SWAP,
        S_OVER
    } turn_state_t;

    localparam logic [1:0] GAN_NONE = 2'b00;
    localparam logic [1:0] GAN_P1   = 2'b01;
    localparam logic [1:0] GAN_P2   = 2'b10;
    localparam logic [1:0] GAN_TIE  = 2'b11;

    // Winner encoding from the final scores.
    function automatic logic [1:0] winner_of(input logic [3:0] p1, input logic [3:0] p2);
        if (p1 > p2) begin
            return GAN_P1;
        end
        if (p1 < p2) begin
            return GAN_P2;
        end
        return GAN_TIE;
    endfunction

endpackage

// File: rtl/card_turn_controller_hold_timer.sv
// Loadable down-counter that keeps a mismatched pair face-up.
module hold_timer #(
    parameter int SHOW_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);
    localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SHOW_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    // Load the hold length, then count down and rest at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= LOAD_VAL;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/card_turn_controller.sv
// Turn sequencer for the 16-card memory game: cursor, flips, pair
// resolution, player alternation, scoring and winner.
module card_turn_controller
    import card_pkg::*;
#(
    parameter int SHOW_CYCLES = 50_000_000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [N_CARDS-1:0][SYM_W-1:0]     sym_in,
    input  logic                              left,
    input  logic                              right,
    input  logic                              sel,
    input  logic                              tiempo_terminado,
    output logic [N_CARDS-1:0][CARD_W-1:0]    arr_cartas,
    output logic [3:0]                        cursor,
    output logic                              jugador,
    output logic [3:0]                        score_p1,
    output logic [3:0]                        score_p2,
    output logic [1:0]                        cartas_sel,
    output logic                              restart_timer,
    output logic [1:0]                        ganador,
    output logic                              game_over
);

    turn_state_t      state_reg;
    logic [SYM_W-1:0] sym_reg    [N_CARDS];
    card_status_t     status_reg [N_CARDS];
    logic [3:0]       a_reg;
    logic [3:0]       b_reg;
    logic             pass_reg;
    logic [3:0]       cursor_next;
    logic             pair_match;
    logic             hold_load;
    logic             hold_done;
    logic [4:0]       total_pairs;

    // Card words are the status and symbol registers side by side.
    generate
        for (genvar gi = 0; gi < N_CARDS; gi++) begin : g_card
            assign arr_cartas[gi] = {status_reg[gi], sym_reg[gi]};
        end
    endgenerate

    // Cursor step: opposing pulses in the same cycle cancel; 4-bit math wraps mod 16.
    always_comb begin
        cursor_next = cursor;
        if (right && !left) begin
            cursor_next = cursor + 4'd1;
        end else if (left && !right) begin
            cursor_next = cursor - 4'd1;
        end
    end

    assign pair_match  = (sym_reg[a_reg] == sym_reg[b_reg]);
    assign hold_load   = (state_reg == S_CHECK) && !pair_match;
    assign total_pairs = {1'b0, score_p1} + {1'b0, score_p2};

    hold_timer #(
        .SHOW_CYCLES(SHOW_CYCLES)
    ) u_hold (
        .clk (clk),
        .rst (rst),
        .load(hold_load),
        .done(hold_done)
    );

    // Main turn FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            for (int i = 0; i < N_CARDS; i++) begin
                sym_reg[i]    <= '0;
                status_reg[i] <= ST_HIDDEN;
            end
            a_reg         <= '0;
            b_reg         <= '0;
            pass_reg      <= 1'b0;
            cursor        <= '0;
            jugador       <= 1'b0;
            score_p1      <= '0;
            score_p2      <= '0;
            cartas_sel    <= '0;
            restart_timer <= 1'b0;
            ganador       <= GAN_NONE;
            game_over     <= 1'b0;
        end else begin
            restart_timer <= 1'b0;
            case (state_reg)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        for (int i = 0; i < N_CARDS; i++) begin
                            sym_reg[i]    <= sym_in[i];
                            status_reg[i] <= ST_HIDDEN;
                        end
                        cursor        <= '0;
                        score_p1      <= '0;
                        score_p2      <= '0;
                        jugador       <= 1'b0;
                        cartas_sel    <= '0;
                        ganador       <= GAN_NONE;
                        game_over     <= 1'b0;
                        restart_timer <= 1'b1;
                        state_reg     <= S_PICK1;
                    end
                end
                S_PICK1: begin
                    cursor <= cursor_next;
                    // Timeout has priority over a simultaneous select.
                    if (tiempo_terminado) begin
                        pass_reg  <= 1'b1;
                        state_reg <= S_SWAP;
                    end else if (sel && status_reg[cursor] == ST_HIDDEN) begin
                        status_reg[cursor] <= ST_FACE_UP;
                        a_reg              <= cursor;
                        cartas_sel         <= 2'd1;
                        state_reg          <= S_PICK2;
                    end
                end
                S_PICK2: begin
                    cursor <= cursor_next;
                    if (tiempo_terminado) begin
                        status_reg[a_reg] <= ST_HIDDEN;
                        pass_reg          <= 1'b1;
                        state_reg         <= S_SWAP;
                    end else if (sel && status_reg[cursor] == ST_HIDDEN) begin
                        status_reg[cursor] <= ST_FACE_UP;
                        b_reg              <= cursor;
                        cartas_sel         <= 2'd2;
                        state_reg          <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (pair_match) begin
                        status_reg[a_reg] <= ST_MATCHED;
                        status_reg[b_reg] <= ST_MATCHED;
                        if (jugador) begin
                            score_p2 <= score_p2 + 4'd1;
                        end else begin
                            score_p1 <= score_p1 + 4'd1;
                        end
                        pass_reg  <= 1'b0;
                        state_reg <= S_SWAP;
                    end else begin
                        // The hold timer is loaded combinationally during this cycle.
                        pass_reg  <= 1'b1;
                        state_reg <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (hold_done) begin
                        status_reg[a_reg] <= ST_HIDDEN;
                        status_reg[b_reg] <= ST_HIDDEN;
                        state_reg         <= S_SWAP;
                    end
                end
                S_SWAP: begin
                    if (pass_reg) begin
                        jugador <= ~jugador;
                    end
                    cartas_sel    <= '0;
                    restart_timer <= 1'b1;
                    if (total_pairs == 5'(N_PAIRS)) begin
                        ganador   <= winner_of(score_p1, score_p2);
                        game_over <= 1'b1;
                        state_reg <= S_OVER;
                    end else begin
                        state_reg <= S_PICK1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_card_turn_controller.sv
// Directed bench for card_turn_controller with a short mismatch hold.
module tb_card_turn_controller;
    import card_pkg::*;

    localparam int SHOW = 4;

    logic clk = 1'b0;
    logic rst;
    logic start, left, right, sel, tiempo_terminado;
    logic [N_CARDS-1:0][SYM_W-1:0]  sym_in;
    logic [N_CARDS-1:0][CARD_W-1:0] arr_cartas;
    logic [3:0] cursor;
    logic       jugador;
    logic [3:0] score_p1, score_p2;
    logic [1:0] cartas_sel;
    logic       restart_timer;
    logic [1:0] ganador;
    logic       game_over;

    card_turn_controller #(.SHOW_CYCLES(SHOW)) dut (
        .clk(clk), .rst(rst), .start(start), .sym_in(sym_in),
        .left(left), .right(right), .sel(sel), .tiempo_terminado(tiempo_terminado),
        .arr_cartas(arr_cartas), .cursor(cursor), .jugador(jugador),
        .score_p1(score_p1), .score_p2(score_p2), .cartas_sel(cartas_sel),
        .restart_timer(restart_timer), .ganador(ganador), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int model_cur = 0;

    typedef struct {
        int l, r, s, t, st;
        int cur, cs, jug, p1, p2, rt, idx, stat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int l, int r, int s, int t, int st, int cur, int cs,
                                int jug, int p1, int p2, int rt, int idx, int stat);
        vec_t v;
        v.l = l; v.r = r; v.s = s; v.t = t; v.st = st;
        v.cur = cur; v.cs = cs; v.jug = jug; v.p1 = p1; v.p2 = p2;
        v.rt = rt; v.idx = idx; v.stat = stat;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int stat_of(input int idx);
        logic [CARD_W-1:0] w;
        w = arr_cartas[idx];
        return int'(w[4:3]);
    endfunction

    // One clock: drive inputs after a falling edge, sample at the next falling edge.
    task automatic cyc(input int l, input int r, input int s, input int t, input int st);
        left = (l != 0); right = (r != 0); sel = (s != 0);
        tiempo_terminado = (t != 0); start = (st != 0);
        @(negedge clk);
        left = 1'b0; right = 1'b0; sel = 1'b0; tiempo_terminado = 1'b0; start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic pick(input int target);
        while (model_cur != target) begin
            cyc(0, 1, 0, 0, 0);
            model_cur = (model_cur + 1) % 16;
        end
        cyc(0, 0, 1, 0, 0);
    endtask

    task automatic turn_match(input int a, input int b);
        pick(a); pick(b); idle(2);
    endtask

    task automatic turn_miss(input int a, input int b);
        pick(a); pick(b); idle(SHOW + 2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        model_cur = 0;
    endtask

    task automatic check_game_end(input string tag, input int p1, input int p2, input int gan);
        int all_matched;
        chk({tag, "_game_over"}, int'(game_over), 1);
        chk({tag, "_ganador"}, int'(ganador), gan);
        chk({tag, "_p1"}, int'(score_p1), p1);
        chk({tag, "_p2"}, int'(score_p2), p2);
        all_matched = 1;
        for (int i = 0; i < N_CARDS; i++) if (stat_of(i) != 2) all_matched = 0;
        chk({tag, "_all_matched"}, all_matched, 1);
        $display("%s: p1=%0d p2=%0d ganador=%0d game_over=%0d", tag, score_p1, score_p2, ganador, game_over);
    endtask

    initial begin
        rst = 1'b1;
        start = 0; left = 0; right = 0; sel = 0; tiempo_terminado = 0;
        for (int i = 0; i < N_CARDS; i++) sym_in[i] = 3'(i / 2);

        // Reset state.
        idle(2);
        chk("rst_arr_zero", int'(arr_cartas == '0), 1);
        chk("rst_cursor", int'(cursor), 0);
        chk("rst_jugador", int'(jugador), 0);
        chk("rst_scores", int'(score_p1) + int'(score_p2), 0);
        chk("rst_cartas_sel", int'(cartas_sel), 0);
        chk("rst_restart", int'(restart_timer), 0);
        chk("rst_ganador", int'(ganador), 0);
        chk("rst_game_over", int'(game_over), 0);
        rst = 1'b0;
        idle(1);

        //          l  r  s  t  st cur cs jug p1 p2 rt idx stat
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1,  0, 0)); // start
        vecs.push_back(mk(0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0,  0, 1)); // flip 0
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0,  1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,  1, 2, 0, 0, 0, 0,  1, 1)); // flip 1
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 2, 0, 1, 0, 0,  1, 2)); // CHECK match
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 1,  0, 2)); // SWAP keep turn
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0,  0, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0,  0, 2));
        vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0,  0, 2)); // matched: ignored
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0,  1, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0,  2, 0, 0, 1, 0, 0,  2, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,  2, 1, 0, 1, 0, 0,  2, 1)); // A=2
        vecs.push_back(mk(1, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0,  1, 2));
        vecs.push_back(mk(0, 0, 1, 0, 0,  1, 1, 0, 1, 0, 0,  1, 2)); // matched: ignored
        vecs.push_back(mk(0, 1, 0, 0, 0,  2, 1, 0, 1, 0, 0,  2, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,  2, 1, 0, 1, 0, 0,  2, 1)); // re-select A: ignored
        vecs.push_back(mk(0, 1, 0, 0, 0,  3, 1, 0, 1, 0, 0,  3, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  4, 1, 0, 1, 0, 0,  4, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,  4, 2, 0, 1, 0, 0,  4, 1)); // B=4, mismatch
        vecs.push_back(mk(0, 0, 0, 0, 0,  4, 2, 0, 1, 0, 0,  4, 1)); // CHECK
        vecs.push_back(mk(0, 1, 0, 0, 0,  4, 2, 0, 1, 0, 0,  4, 1)); // SHOW: no cursor move
        vecs.push_back(mk(0, 0, 0, 0, 0,  4, 2, 0, 1, 0, 0,  4, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  4, 2, 0, 1, 0, 0,  2, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  4, 2, 0, 1, 0, 0,  4, 0)); // hidden again
        vecs.push_back(mk(0, 0, 0, 0, 0,  4, 0, 1, 1, 0, 1,  2, 0)); // SWAP pass turn
        vecs.push_back(mk(1, 0, 0, 0, 0,  3, 0, 1, 1, 0, 0,  4, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  2, 0, 1, 1, 0, 0,  2, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  1, 0, 1, 1, 0, 0,  1, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0,  0, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 15, 0, 1, 1, 0, 0, 15, 0)); // wrap down
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0,  0, 2)); // wrap up
        vecs.push_back(mk(1, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0,  0, 2)); // both: no move
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 1, 1, 0, 0,  1, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0,  2, 0, 1, 1, 0, 0,  2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  3, 0, 1, 1, 0, 0,  3, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  4, 0, 1, 1, 0, 0,  4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  5, 0, 1, 1, 0, 0,  5, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,  5, 1, 1, 1, 0, 0,  5, 1)); // A=5
        vecs.push_back(mk(0, 1, 0, 0, 0,  6, 1, 1, 1, 0, 0,  5, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0,  6, 1, 1, 1, 0, 0,  6, 0)); // timeout beats sel
        vecs.push_back(mk(0, 0, 0, 0, 0,  6, 0, 0, 1, 0, 1,  5, 0)); // SWAP pass turn
        vecs.push_back(mk(0, 0, 0, 1, 0,  6, 0, 0, 1, 0, 0,  6, 0)); // timeout in PICK1
        vecs.push_back(mk(0, 0, 0, 0, 0,  6, 0, 1, 1, 0, 1,  6, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  6, 0, 1, 1, 0, 0,  0, 2)); // start mid-game ignored
        vecs.push_back(mk(0, 0, 1, 0, 0,  6, 1, 1, 1, 0, 0,  6, 1));

        foreach (vecs[k]) begin
            vec_t v;
            v = vecs[k];
            cyc(v.l, v.r, v.s, v.t, v.st);
            $display("vec %0d: cursor=%0d cartas_sel=%0d jugador=%0d p1=%0d p2=%0d rt=%0d card%0d=%0d",
                     k, cursor, cartas_sel, jugador, score_p1, score_p2, restart_timer, v.idx, stat_of(v.idx));
            chk($sformatf("v%0d_cursor", k), int'(cursor), v.cur);
            chk($sformatf("v%0d_cartas_sel", k), int'(cartas_sel), v.cs);
            chk($sformatf("v%0d_jugador", k), int'(jugador), v.jug);
            chk($sformatf("v%0d_p1", k), int'(score_p1), v.p1);
            chk($sformatf("v%0d_p2", k), int'(score_p2), v.p2);
            chk($sformatf("v%0d_restart", k), int'(restart_timer), v.rt);
            chk($sformatf("v%0d_status", k), stat_of(v.idx), v.stat);
        end

        // Full game: P1 takes 5 pairs, misses, P2 takes the last 3.
        do_reset();
        cyc(0, 0, 0, 0, 1);
        turn_match(0, 1); turn_match(2, 3); turn_match(4, 5); turn_match(6, 7); turn_match(8, 9);
        turn_miss(10, 12);
        chk("g1_turn_passed", int'(jugador), 1);
        turn_match(10, 11); turn_match(12, 13); turn_match(14, 15);
        check_game_end("g1", 5, 3, 1);
        idle(3);
        chk("g1_ganador_hold", int'(ganador), 1);
        cyc(0, 0, 0, 0, 1);
        chk("g1_restart_gan", int'(ganador), 0);
        chk("g1_restart_over", int'(game_over), 0);
        chk("g1_restart_pulse", int'(restart_timer), 1);
        chk("g1_restart_hidden", stat_of(0), 0);
        model_cur = 0;

        // Tie game: 4 pairs each.
        turn_match(0, 1); turn_match(2, 3); turn_match(4, 5); turn_match(6, 7);
        turn_miss(8, 10);
        turn_match(8, 9); turn_match(10, 11); turn_match(12, 13); turn_match(14, 15);
        check_game_end("g2", 4, 4, 3);

        // Reset asserted in the middle of SHOW.
        do_reset();
        cyc(0, 0, 0, 0, 1);
        pick(0); pick(2);
        idle(2);
        chk("mid_show_faceup", stat_of(2), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_arr_zero", int'(arr_cartas == '0), 1);
        chk("async_cursor", int'(cursor), 0);
        chk("async_cartas_sel", int'(cartas_sel), 0);
        chk("async_p1", int'(score_p1), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 1, 0, 0);
        chk("post_rst_idle_sel", int'(arr_cartas == '0), 1);
        chk("post_rst_restart", int'(restart_timer), 0);
        chk("post_rst_game_over", int'(game_over), 0);
        $display("rst mid-SHOW: cursor=%0d cartas_sel=%0d", cursor, cartas_sel);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/card_turn_controller.md
# card_turn_controller

Gameplay sequencer for the 16-card memory game. It owns the card-state array that the game-screen video generator draws. It takes the shuffled symbol deck, moves a selection cursor, and flips up to two cards per turn. It then resolves each pair as match or mismatch, alternates the two players, keeps score and declares the winner. It sits between the top-level FSM and button inputs on one side, and the video generator and 15 s turn counter on the other.

## Interface
- `SHOW_CYCLES`, default 50_000_000: clk cycles a mismatched pair stays face-up (1 s at 50 MHz).
- `clk` in 1: system clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse; load deck and begin game.
- `sym_in` in 16x3: shuffled symbols, index 0..15; each symbol 0..7 appears exactly twice; sampled on `start`.
- `left`, `right` in 1: single-cycle cursor-move pulses (debounced upstream).
- `sel` in 1: single-cycle select pulse.
- `tiempo_terminado` in 1: single-cycle pulse, turn time expired.
- `arr_cartas` out 16x5: per card, [4:3] status (00 hidden, 01 face-up, 10 matched), [2:0] symbol.
- `cursor` out 4: highlighted card index.
- `jugador` out 1: current player (0 = P1, 1 = P2).
- `score_p1`, `score_p2` out 4: pairs won, 0..8.
- `cartas_sel` out 2: cards face-up this turn (0..2).
- `restart_timer` out 1: one-cycle pulse to restart the 15 s counter.
- `ganador` out 2: 00 none, 01 P1, 10 P2, 11 tie.
- `game_over` out 1: high in OVER.

## Operation
- States are IDLE, PICK1, PICK2, SHOW, CHECK, SWAP and OVER.
- **IDLE**
  - On `start`: latch `sym_in`, set all statuses to hidden, zero cursor and scores, set `jugador` to 0.
  - Pulse `restart_timer` and go to PICK1.
- **Cursor movement**
  - Active in PICK1 and PICK2 only.
  - `right` adds 1 mod 16 (15 wraps to 0); `left` subtracts 1 mod 16 (0 wraps to 15).
  - Both pulses in the same cycle: no move.
- **PICK1**
  - `sel` on a hidden card: set it face-up, record index A, `cartas_sel`=1, go to PICK2.
  - `sel` on a face-up or matched card: ignored.
- **PICK2**
  - `sel` on a hidden card: set it face-up, record index B, `cartas_sel`=2, go to CHECK.
  - `sel` on a non-hidden card: ignored, including re-selecting A.
- **CHECK** (one cycle)
  - Symbols equal: both cards become matched, current player's score +1, go to SWAP with the turn kept.
  - Symbols differ: load the hold counter with SHOW_CYCLES-1 and go to SHOW.
- **SHOW**
  - Count down; when the count reaches 0, set A and B hidden and go to SWAP with the turn passed.
- **SWAP** (one cycle)
  - Pass turn: toggle `jugador`. Keep turn: no toggle.
  - In both cases: `cartas_sel`=0 and pulse `restart_timer`.
  - If total matched pairs = 8, go to OVER instead of PICK1.
- **Timeout** (`tiempo_terminado`)
  - In PICK1: go to SWAP, pass turn.
  - In PICK2: card A becomes hidden, go to SWAP, pass turn.
  - Ignored in CHECK, SHOW, SWAP, IDLE and OVER.
  - Same cycle as `sel` in PICK1/PICK2: the timeout wins and `sel` is dropped.
- **OVER**
  - `ganador` is 01 if `score_p1` > `score_p2`, 10 if less, 11 if equal; it holds until `start` or `rst`.
  - `start` in OVER: behaves as in IDLE; `ganador` returns to 00.
- `start` in any other state: ignored.

## Timing
- Reset values:
  - All `arr_cartas` = 5'b00000.
  - `cursor`, `jugador`, scores, `cartas_sel`, `ganador` = 0.
  - `restart_timer`, `game_over` = 0.
  - State = IDLE.
- Mid-game `rst` discards all progress immediately (asynchronous assertion, synchronous release).
- Outputs are registered. A flip is visible one cycle after the `sel` edge.
- Match resolution: matched status appears 2 cycles after the second `sel` (CHECK, then SWAP).
- Mismatch: cards return to hidden SHOW_CYCLES+1 cycles after CHECK; SWAP follows one cycle later.
- `restart_timer` is exactly one cycle wide, issued from IDLE/OVER→PICK1 and from SWAP.
- Score width: 4 bits; saturation is never reached (maximum total 8).

## Structure
- Package `card_pkg` holds:
  - `N_CARDS`=16, `SYM_W`=3, `CARD_W`=5.
  - Status enum: HIDDEN, FACE_UP, MATCHED.
  - State enum `turn_state_t`.
  - `ganador` encodings.
- Sub-module `hold_timer`: loadable down-counter, width $clog2(SHOW_CYCLES).
  - Ports: `clk`, `rst`, `load`, `done`.
  - `done` is high when the count is 0.
- The cursor and pair compare stay inline.

## Test plan
SHOW_CYCLES=4 for all benches.
- Reset, `start` with `sym_in`={0,0,1,1,…,7,7}, `sel` at 0, `right`, `sel` at 1 → cards 0 and 1 matched, `score_p1`=1, `jugador`=0, `restart_timer` pulses once.
- `sel` at 0, `right`×2, `sel` at 2 (symbols 0 vs 1) → both face-up for 4 cycles, then hidden, `jugador`=1, scores unchanged.
- Cursor at 0, `left` → cursor=15; then `right` → cursor=0; `left` and `right` in the same cycle → no change.
- PICK2 with A=5, `tiempo_terminado` and `sel` in the same cycle → card 5 hidden, turn passes, no second flip.
- Re-select A, or select a matched card → no status change, `cartas_sel` unchanged.
- Full game with P1 taking 5 pairs and P2 taking 3 → `game_over`=1, `ganador`=01. A 4/4 run → 11. `rst` asserted mid-SHOW → all outputs return to reset values.
